// File: rtl/wb_arbiter.sv
// Writeback arbiter: two result FIFOs (ALU, LSU) sharing one RF write port and the
// ROB completion port, round-robin granted one result per cycle.
module wb_arbiter #(
   parameter int unsigned ROBINDEX = 6,
   parameter int unsigned DEPTH    = 4,
   parameter int unsigned PTRW     = 2
) (
   input  logic                CLK,
   input  logic                RESET,
   input  logic                FREEZE,
   input  logic                ALU_valid_IN,
   output logic                ALU_ready_OUT,
   input  logic [31:0]         ALU_data_IN,
   input  logic [5:0]          ALU_dest_IN,
   input  logic                ALU_regwrite_IN,
   input  logic [ROBINDEX-1:0] ALU_rob_IN,
   input  logic                LSU_valid_IN,
   output logic                LSU_ready_OUT,
   input  logic [31:0]         LSU_data_IN,
   input  logic [5:0]          LSU_dest_IN,
   input  logic                LSU_regwrite_IN,
   input  logic [ROBINDEX-1:0] LSU_rob_IN,
   output logic [31:0]         write_register_data,
   output logic [5:0]          write_register_index,
   output logic                write_register_flag,
   output logic                ROB_complete_OUT,
   output logic [ROBINDEX-1:0] ROB_complete_index_OUT
);

   localparam int unsigned NSRC     = 2;
   localparam logic [PTRW:0] FULL_CNT = (PTRW+1)'(DEPTH);

   typedef struct packed {
      logic [31:0]         data;
      logic [5:0]          dest;
      logic                regwrite;
      logic [ROBINDEX-1:0] rob;
   } entry_t;

   // Source index 0 is the ALU path, 1 is the load/store path.
   entry_t            mem_q   [NSRC][DEPTH];
   entry_t            mem_d   [NSRC][DEPTH];
   logic [PTRW-1:0]   rptr_q  [NSRC];
   logic [PTRW-1:0]   rptr_d  [NSRC];
   logic [PTRW-1:0]   wptr_q  [NSRC];
   logic [PTRW-1:0]   wptr_d  [NSRC];
   logic [PTRW:0]     cnt_q   [NSRC];
   logic [PTRW:0]     cnt_d   [NSRC];
   entry_t            in_c    [NSRC];
   logic              valid_c [NSRC];
   logic              ready_c [NSRC];
   logic              push_c  [NSRC];
   logic              ne_c    [NSRC];
   logic              gnt_c   [NSRC];

   logic                prio_q, prio_d;
   logic [31:0]         wr_data_q, wr_data_d;
   logic [5:0]          wr_index_q, wr_index_d;
   logic                wr_flag_q, wr_flag_d;
   logic                cmp_q, cmp_d;
   logic [ROBINDEX-1:0] cmp_idx_q, cmp_idx_d;

   // Handshake and round-robin grant
   always_comb begin
      in_c[0]    = {ALU_data_IN, ALU_dest_IN, ALU_regwrite_IN, ALU_rob_IN};
      in_c[1]    = {LSU_data_IN, LSU_dest_IN, LSU_regwrite_IN, LSU_rob_IN};
      valid_c[0] = ALU_valid_IN;
      valid_c[1] = LSU_valid_IN;
      for (int s = 0; s < NSRC; s++) begin
         ready_c[s] = !RESET && !FREEZE && (cnt_q[s] < FULL_CNT);
         push_c[s]  = valid_c[s] && ready_c[s];
         ne_c[s]    = (cnt_q[s] != '0);
      end
      gnt_c[0] = !FREEZE && ne_c[0] && (!ne_c[1] || !prio_q);
      gnt_c[1] = !FREEZE && ne_c[1] && (!ne_c[0] ||  prio_q);
   end

   assign ALU_ready_OUT = ready_c[0];
   assign LSU_ready_OUT = ready_c[1];

   // FIFO next state
   always_comb begin
      for (int s = 0; s < NSRC; s++) begin
         mem_d[s]  = mem_q[s];
         rptr_d[s] = rptr_q[s];
         wptr_d[s] = wptr_q[s];
         cnt_d[s]  = cnt_q[s];
         if (push_c[s]) begin
            mem_d[s][wptr_q[s]] = in_c[s];
            wptr_d[s]           = wptr_q[s] + PTRW'(1);
         end
         if (gnt_c[s]) begin
            rptr_d[s] = rptr_q[s] + PTRW'(1);
         end
         case ({push_c[s], gnt_c[s]})
            2'b10:   cnt_d[s] = cnt_q[s] + (PTRW+1)'(1);
            2'b01:   cnt_d[s] = cnt_q[s] - (PTRW+1)'(1);
            default: cnt_d[s] = cnt_q[s];
         endcase
      end
   end

   // Priority flips to the source that was not just served
   always_comb begin
      prio_d = prio_q;
      if (gnt_c[0]) begin
         prio_d = 1'b1;
      end else if (gnt_c[1]) begin
         prio_d = 1'b0;
      end
   end

   // Writeback outputs; everything holds under FREEZE, strobes included
   always_comb begin
      wr_data_d  = wr_data_q;
      wr_index_d = wr_index_q;
      wr_flag_d  = wr_flag_q;
      cmp_d      = cmp_q;
      cmp_idx_d  = cmp_idx_q;
      if (!FREEZE) begin
         wr_flag_d = 1'b0;
         cmp_d     = 1'b0;
         for (int s = 0; s < NSRC; s++) begin
            if (gnt_c[s]) begin
               wr_data_d  = mem_q[s][rptr_q[s]].data;
               wr_index_d = mem_q[s][rptr_q[s]].dest;
               wr_flag_d  = mem_q[s][rptr_q[s]].regwrite;
               cmp_d      = 1'b1;
               cmp_idx_d  = mem_q[s][rptr_q[s]].rob;
            end
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         for (int s = 0; s < NSRC; s++) begin
            rptr_q[s] <= '0;
            wptr_q[s] <= '0;
            cnt_q[s]  <= '0;
         end
         prio_q     <= 1'b0;
         wr_data_q  <= '0;
         wr_index_q <= '0;
         wr_flag_q  <= 1'b0;
         cmp_q      <= 1'b0;
         cmp_idx_q  <= '0;
      end else begin
         for (int s = 0; s < NSRC; s++) begin
            rptr_q[s] <= rptr_d[s];
            wptr_q[s] <= wptr_d[s];
            cnt_q[s]  <= cnt_d[s];
         end
         prio_q     <= prio_d;
         wr_data_q  <= wr_data_d;
         wr_index_q <= wr_index_d;
         wr_flag_q  <= wr_flag_d;
         cmp_q      <= cmp_d;
         cmp_idx_q  <= cmp_idx_d;
      end
   end

   // Storage needs no reset; pushes are already blocked while RESET is high
   always_ff @(posedge CLK) begin
      mem_q <= mem_d;
   end

   assign write_register_data    = wr_data_q;
   assign write_register_index   = wr_index_q;
   assign write_register_flag    = wr_flag_q;
   assign ROB_complete_OUT       = cmp_q;
   assign ROB_complete_index_OUT = cmp_idx_q;

endmodule
